slave: RTL and testbench

// - AXI-Stream slave ingress stage of the resizer; accepts S_KEEP_WIDTH-lane beats.
// - Packs each accepted beat into one flat entry: per lane {last, keep, data}.
// - Hands entries to the input buffer through a valid/enable handshake.
// - Full-throughput 2-deep skid register, so s_ready_o never depends combinationally on en.

---
 rtl/resizer_pkg.sv | 38 +++
 rtl/slave_skid.sv | 71 +++++++
 rtl/slave.sv | 49 ++++
 tb/tb_slave.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resizer_pkg.sv
// Shared resizer types, lane layout and the beat-to-entry packing helper.
// Lane i of an entry is {last, keep, data} at bits [i*LANE_W +: LANE_W].
package resizer_pkg;

  localparam int S_KEEP_WIDTH    = 3;
  localparam int T_DATA_WIDTH    = 1;
  localparam int LANE_W          = T_DATA_WIDTH + 2;
  localparam int BUF_IN_ENTRY_SZ = LANE_W * S_KEEP_WIDTH;

  localparam int DATA_LSB = 0;
  localparam int KEEP_BIT = T_DATA_WIDTH;
  localparam int LAST_BIT = T_DATA_WIDTH + 1;

  typedef logic [T_DATA_WIDTH-1:0]    lane_data_t;
  typedef logic [BUF_IN_ENTRY_SZ-1:0] entry_t;

  // Last flag lands in the highest kept lane; lane 0 when nothing is kept.
  function automatic entry_t pack_entry(
    input logic [S_KEEP_WIDTH-1:0] keep,
    input logic                    last,
    input lane_data_t              data [S_KEEP_WIDTH]
  );
    entry_t e;
    int     last_lane;
    e         = '0;
    last_lane = 0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      e[i*LANE_W+DATA_LSB +: T_DATA_WIDTH] = data[i];
      e[i*LANE_W+KEEP_BIT]                 = keep[i];
      if (keep[i]) last_lane = i;
    end
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      e[i*LANE_W+LAST_BIT] = last && (i == last_lane);
    end
    return e;
  endfunction

endpackage

// File: rtl/slave_skid.sv
// Generic 2-slot (main + skid) register slice; 1-cycle latency, full throughput.
// in_ready is registered and high iff the skid slot is empty.
module slave_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_en,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld, main_vld_nxt;
  logic             skid_vld, skid_vld_nxt;
  logic [WIDTH-1:0] main_dat, main_dat_nxt;
  logic [WIDTH-1:0] skid_dat, skid_dat_nxt;
  logic             rdy_nxt;
  logic             accept, consume;

  assign accept    = in_valid & in_ready;
  assign consume   = main_vld & out_en;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
      in_ready <= 1'b0;
    end else begin
      main_vld <= main_vld_nxt;
      skid_vld <= skid_vld_nxt;
      main_dat <= main_dat_nxt;
      skid_dat <= skid_dat_nxt;
      in_ready <= rdy_nxt;
    end
  end

  // in_ready is low whenever skid is full, so accept and a full skid never coincide.
  always_comb begin
    main_vld_nxt = main_vld;
    skid_vld_nxt = skid_vld;
    main_dat_nxt = main_dat;
    skid_dat_nxt = skid_dat;
    if (consume) begin
      if (skid_vld) begin
        main_dat_nxt = skid_dat;
        skid_vld_nxt = 1'b0;
      end else if (accept) begin
        main_dat_nxt = in_data;
      end else begin
        main_vld_nxt = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_vld_nxt = 1'b1;
        main_dat_nxt = in_data;
      end else begin
        skid_vld_nxt = 1'b1;
        skid_dat_nxt = in_data;
      end
    end
    rdy_nxt = ~skid_vld_nxt;
  end

endmodule

// File: rtl/slave.sv
// AXI-Stream ingress: packs each beat into one entry, drops null beats; 1-cycle latency.
// s_ready_o comes from the registered skid state, never combinationally from en.
module slave
  import resizer_pkg::*;
#(
  parameter  int S_KEEP_WIDTH    = resizer_pkg::S_KEEP_WIDTH,
  parameter  int T_DATA_WIDTH    = resizer_pkg::T_DATA_WIDTH,
  localparam int BUF_IN_ENTRY_SZ = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid_i,
  input  logic                       s_last_i,
  input  logic [S_KEEP_WIDTH-1:0]    s_keep_i,
  input  logic [T_DATA_WIDTH-1:0]    s_data_i [S_KEEP_WIDTH],
  output logic                       s_ready_o,
  input  logic                       en,
  output logic                       slave_entry_valid,
  output logic [BUF_IN_ENTRY_SZ-1:0] slave_entry
);

  lane_data_t                 data_arr [S_KEEP_WIDTH];
  logic [BUF_IN_ENTRY_SZ-1:0] packed_entry;
  logic                       null_beat;

  always_comb begin
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      data_arr[i] = s_data_i[i];
    end
    packed_entry = pack_entry(s_keep_i, s_last_i, data_arr);
  end

  // A beat with no kept lanes and no last carries nothing: accept it but store nothing.
  assign null_beat = ~|s_keep_i & ~s_last_i;

  slave_skid #(
    .WIDTH (BUF_IN_ENTRY_SZ)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid_i & ~null_beat),
    .in_ready  (s_ready_o),
    .in_data   (packed_entry),
    .out_valid (slave_entry_valid),
    .out_en    (en),
    .out_data  (slave_entry)
  );

endmodule

// File: tb/tb_slave.sv
// Scoreboard bench for slave: expected entries queued on accept, compared on consume.
module tb_slave;

  localparam int KW = 3;
  localparam int DW = 1;
  localparam int EW = (DW + 2) * KW;

  logic          clk;
  logic          rst_n;
  logic          s_valid_i;
  logic          s_last_i;
  logic [KW-1:0] s_keep_i;
  logic [DW-1:0] s_data_i [KW];
  logic          s_ready_o;
  logic          en;
  logic          slave_entry_valid;
  logic [EW-1:0] slave_entry;

  int checks = 0;
  int fails  = 0;

  logic [EW-1:0] sb [$];
  logic          hold_vld = 1'b0;
  logic [EW-1:0] hold_dat = '0;

  slave dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_valid_i         (s_valid_i),
    .s_last_i          (s_last_i),
    .s_keep_i          (s_keep_i),
    .s_data_i          (s_data_i),
    .s_ready_o         (s_ready_o),
    .en                (en),
    .slave_entry_valid (slave_entry_valid),
    .slave_entry       (slave_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packing, lane-by-lane with a top-down search for the last lane.
  function automatic logic [EW-1:0] model(input logic [KW-1:0] k, input logic l, input logic [KW-1:0] d);
    logic [EW-1:0] e;
    logic          placed;
    e = '0;
    for (int i = 0; i < KW; i++) begin
      e[i*3]   = d[i];
      e[i*3+1] = k[i];
    end
    placed = 1'b0;
    if (l) begin
      for (int i = KW - 1; i >= 0; i--) begin
        if (k[i] && !placed) begin
          e[i*3+2] = 1'b1;
          placed   = 1'b1;
        end
      end
      if (!placed) e[2] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [KW-1:0] cur_data();
    logic [KW-1:0] d;
    for (int i = 0; i < KW; i++) d[i] = s_data_i[i][0];
    return d;
  endfunction

  task automatic set_beat(input logic [KW-1:0] k, input logic l, input logic [KW-1:0] d);
    s_keep_i = k;
    s_last_i = l;
    for (int i = 0; i < KW; i++) s_data_i[i] = d[i];
  endtask

  // Mid-cycle monitor: handshakes seen here happen at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!slave_entry_valid || slave_entry !== hold_dat) begin
          fails++;
          $display("FAIL hold_stable: got vld=%0b entry=%h, want vld=1 entry=%h", slave_entry_valid, slave_entry, hold_dat);
        end
      end
      if (slave_entry_valid && en) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: got entry=%h, want no entry", slave_entry);
        end else begin
          logic [EW-1:0] exp_e;
          exp_e = sb.pop_front();
          if (slave_entry !== exp_e) begin
            fails++;
            $display("FAIL sb_entry: got %h, want %h", slave_entry, exp_e);
          end
        end
      end
      if (s_valid_i && s_ready_o && (|s_keep_i || s_last_i))
        sb.push_back(model(s_keep_i, s_last_i, cur_data()));
      hold_vld <= slave_entry_valid && !en;
      hold_dat <= slave_entry;
    end
  end

  // Starts and returns at posedge+2; returns after the accepting edge.
  task automatic send_one(input logic [KW-1:0] k, input logic l, input logic [KW-1:0] d);
    logic ok;
    ok = 1'b0;
    set_beat(k, l, d);
    s_valid_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: got ready=%0b, want 1 within 50 cycles", s_ready_o);
    end
    @(posedge clk); #2;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !slave_entry_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL drain: got pending=%0d vld=%0b, want 0 and 0", sb.size(), slave_entry_valid);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; s_valid_i = 1'b0;
    set_beat('0, 1'b0, '0);
    #12;
    checks += 3;
    if (s_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, want 0", s_ready_o); end
    if (slave_entry_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, want 0", slave_entry_valid); end
    if (slave_entry !== '0) begin fails++; $display("FAIL reset_entry: got %h, want 0", slave_entry); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready_o !== 1'b1) begin fails++; $display("FAIL release_ready: got %b, want 1", s_ready_o); end
    #1;
  endtask

  task automatic test_full_beat();
    en = 1'b1;
    set_beat(3'b111, 1'b0, 3'b101);
    s_valid_i = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (!slave_entry_valid || slave_entry !== 9'h0D3) begin
        fails++;
        $display("FAIL full_beat[%0d]: got vld=%0b entry=%h, want vld=1 entry=0d3", n, slave_entry_valid, slave_entry);
      end
    end
    @(posedge clk); #2;
    s_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_last_partial();
    en = 1'b1;
    send_one(3'b011, 1'b1, 3'b001);
    @(negedge clk);
    checks++;
    if (!slave_entry_valid || slave_entry !== 9'b000_110_011) begin
      fails++;
      $display("FAIL last_partial: got vld=%0b entry=%b, want vld=1 entry=000110011", slave_entry_valid, slave_entry);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e1;
    logic          ok;
    en = 1'b0;
    e1 = model(3'b111, 1'b0, 3'b001);
    send_one(3'b111, 1'b0, 3'b001);
    send_one(3'b101, 1'b1, 3'b110);
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0 || slave_entry !== e1) begin
      fails++;
      $display("FAIL bp_full: got ready=%b entry=%h, want ready=0 entry=%h", s_ready_o, slave_entry, e1);
    end
    @(posedge clk); #2;
    set_beat(3'b010, 1'b0, 3'b011);
    s_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (s_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL bp_ready_low[%0d]: got %b, want 0", n, s_ready_o);
      end
    end
    @(posedge clk); #2;
    en = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_ready_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_beat3_accept: got ready=0, want 1"); end
    @(posedge clk); #2;
    s_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_null();
    en = 1'b1;
    send_one(3'b000, 1'b0, 3'b101);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (slave_entry_valid !== 1'b0) begin
        fails++;
        $display("FAIL null_dropped[%0d]: got vld=%b, want 0", n, slave_entry_valid);
      end
    end
    @(posedge clk); #2;
    send_one(3'b000, 1'b1, 3'b000);
    @(negedge clk);
    checks++;
    if (!slave_entry_valid || slave_entry !== 9'b000_000_100) begin
      fails++;
      $display("FAIL null_last: got vld=%0b entry=%b, want vld=1 entry=000000100", slave_entry_valid, slave_entry);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      set_beat(KW'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), KW'($urandom_range(0, 7)));
      s_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready_o !== 1'b1 || (n > 0 && slave_entry_valid !== 1'b1)) begin
        fails++;
        $display("FAIL b2b_stream[%0d]: got ready=%b vld=%b, want 1 and 1", n, s_ready_o, slave_entry_valid);
      end
      @(posedge clk); #2;
    end
    s_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_async_reset();
    logic [EW-1:0] e3;
    en = 1'b0;
    send_one(3'b110, 1'b0, 3'b010);
    send_one(3'b001, 1'b1, 3'b111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (slave_entry_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b, want 0", slave_entry_valid); end
    if (slave_entry !== '0) begin fails++; $display("FAIL arst_entry: got %h, want 0", slave_entry); end
    if (s_ready_o !== 1'b0) begin fails++; $display("FAIL arst_ready: got %b, want 0", s_ready_o); end
    sb.delete();
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    en = 1'b1;
    e3 = model(3'b100, 1'b1, 3'b100);
    send_one(3'b100, 1'b1, 3'b100);
    @(negedge clk);
    checks++;
    if (!slave_entry_valid || slave_entry !== e3) begin
      fails++;
      $display("FAIL arst_first_entry: got vld=%0b entry=%h, want vld=1 entry=%h", slave_entry_valid, slave_entry, e3);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_last_partial();
    test_backpressure();
    test_null();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
